// File: rtl/romulus_pkg.sv
// romulus_pkg: shared constants, FSM state type and per-byte LFSR maps
// for the Romulus/Skinny tweakey-lane scheduler.
//   BYTE_W / LANE_BYTES / LANE_W : lane geometry (16 bytes of 8 bits)
//   TK2 / TK3                    : selectors for the forward map
//   state_t                      : scheduler FSM state {IDLE, RUN}
//   t3_map / t2_map              : single-iteration byte maps (mutual inverses)
package romulus_pkg;

  localparam int BYTE_W     = 8;
  localparam int LANE_BYTES = 16;
  localparam int LANE_W     = BYTE_W * LANE_BYTES;

  localparam int TK2 = 2;
  localparam int TK3 = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // T3: shift right, feedback x0^x6 into bit 7
  function automatic logic [7:0] t3_map(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  // T2: shift left, feedback x7^x5 into bit 0
  function automatic logic [7:0] t2_map(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

endpackage

// File: rtl/tk_lfsr_step.sv
// tk_lfsr_step: one LFSR iteration applied independently to all 16 bytes
// of a tweakey lane. Purely combinational.
//   lane      in  128  lane value
//   dir       in  1    0 = forward map, 1 = inverse map
//   lane_next out 128  lane after one iteration
// Parameter TK picks the forward map: TK3 -> T3, TK2 -> T2.
module tk_lfsr_step
  import romulus_pkg::*;
#(
  parameter int TK = 3
) (
  input  logic [LANE_W-1:0] lane,
  input  logic              dir,
  output logic [LANE_W-1:0] lane_next
);

  // T3 is used when it is the forward map and dir=0, or when it is the
  // inverse map (TK2 lane) and dir=1.
  logic use_t3;
  assign use_t3 = (TK == TK2) ? dir : ~dir;

  generate
    for (genvar gi = 0; gi < LANE_BYTES; gi++) begin : g_byte
      logic [BYTE_W-1:0] b;
      assign b = lane[gi*BYTE_W +: BYTE_W];
      assign lane_next[gi*BYTE_W +: BYTE_W] = use_t3 ? t3_map(b) : t2_map(b);
    end
  endgenerate

endmodule

// File: rtl/tk_lfsr_sched.sv
// tk_lfsr_sched: registered tweakey-lane LFSR engine. Each active cycle
// advances every byte of the lane by STEPS iterations of the forward or
// inverse map. Runs nsteps_i cycles autonomously or single-steps.
//   clk, rst   clock / asynchronous active-high reset
//   load_i     capture key_i into the lane (aborts a run)
//   key_i      lane value to load
//   start_i    start a run of nsteps_i active cycles (IDLE only)
//   dir_i      0 forward / 1 inverse, sampled on start_i or step_i
//   nsteps_i   run length in cycles; 0 gives an immediate done pulse
//   step_i     single active cycle (IDLE only)
//   key_o      current lane register
//   busy_o     high while running
//   done_o     one-cycle pulse alongside the final lane value
//   cnt_o      active cycles remaining
// STEPS is expected in 1..4.
module tk_lfsr_sched
  import romulus_pkg::*;
#(
  parameter int STEPS = 2,
  parameter int TK    = 3,
  parameter int CW    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LANE_W-1:0] key_i,
  input  logic              start_i,
  input  logic              dir_i,
  input  logic [CW-1:0]     nsteps_i,
  input  logic              step_i,
  output logic [LANE_W-1:0] key_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CW-1:0]     cnt_o
);

  state_t            state_reg, state_next;
  logic [LANE_W-1:0] lane_reg,  lane_next;
  logic [CW-1:0]     cnt_reg,   cnt_next;
  logic              dir_reg,   dir_next;
  logic              done_reg,  done_next;

  // A run uses the direction latched at start; a single step uses dir_i live.
  logic active_dir;
  assign active_dir = (state_reg == RUN) ? dir_reg : dir_i;

  // STEPS iterations chained combinationally off the lane register.
  logic [LANE_W-1:0] stage [STEPS+1];
  assign stage[0] = lane_reg;

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
      tk_lfsr_step #(.TK(TK)) u_step (
        .lane      (stage[gi]),
        .dir       (active_dir),
        .lane_next (stage[gi+1])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load_i) begin
          lane_next = key_i;
        end else if (start_i) begin
          if (nsteps_i == '0) begin
            done_next = 1'b1;
          end else begin
            dir_next   = dir_i;
            cnt_next   = nsteps_i;
            state_next = RUN;
          end
        end else if (step_i) begin
          dir_next  = dir_i;
          lane_next = stage[STEPS];
        end
      end
      RUN: begin
        if (load_i) begin
          // abort: no done pulse
          lane_next  = key_i;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          lane_next = stage[STEPS];
          cnt_next  = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      lane_reg  <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      done_reg  <= done_next;
    end
  end

  assign key_o  = lane_reg;
  assign busy_o = (state_reg == RUN);
  assign done_o = done_reg;
  assign cnt_o  = cnt_reg;

endmodule

// File: tb/tb_tk_lfsr_sched.sv
// tb_tk_lfsr_sched: drives four scheduler instances (TK3/STEPS=2 and
// TK2/STEPS=1,3,4) with identical stimulus and compares each against a
// byte-level arithmetic reference of the LFSR maps.
module tb_tk_lfsr_sched;

  localparam int NDUT = 4;
  localparam int CW   = 7;
  // per-instance configuration, 4 bits per entry
  localparam logic [15:0] STEPS_P = {4'd4, 4'd3, 4'd1, 4'd2};
  localparam logic [15:0] TK_P    = {4'd2, 4'd2, 4'd2, 4'd3};

  logic           clk = 1'b0;
  logic           rst;
  logic           load_i;
  logic [127:0]   key_i;
  logic           start_i;
  logic           dir_i;
  logic [CW-1:0]  nsteps_i;
  logic           step_i;

  logic [127:0]   key_o  [NDUT];
  logic           busy_o [NDUT];
  logic           done_o [NDUT];
  logic [CW-1:0]  cnt_o  [NDUT];

  logic [127:0]   exp_key [NDUT];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      tk_lfsr_sched #(
        .STEPS (int'(STEPS_P[gi*4 +: 4])),
        .TK    (int'(TK_P[gi*4 +: 4])),
        .CW    (CW)
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_i),
        .key_i    (key_i),
        .start_i  (start_i),
        .dir_i    (dir_i),
        .nsteps_i (nsteps_i),
        .step_i   (step_i),
        .key_o    (key_o[gi]),
        .busy_o   (busy_o[gi]),
        .done_o   (done_o[gi]),
        .cnt_o    (cnt_o[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: one active cycle = STEPS map iterations on each byte.
  function automatic logic [127:0] ref_cycle(input logic [127:0] v, input int d, input logic dir);
    logic [127:0] r;
    int steps;
    int tk;
    int x;
    int fb;
    r     = v;
    steps = int'(STEPS_P[d*4 +: 4]);
    tk    = int'(TK_P[d*4 +: 4]);
    for (int i = 0; i < 16; i++) begin
      x = int'(r[8*i +: 8]);
      for (int s = 0; s < steps; s++) begin
        if ((tk == 3) != dir) begin
          fb = (x ^ (x >> 6)) & 1;
          x  = (x >> 1) | (fb << 7);
        end else begin
          fb = ((x >> 7) ^ (x >> 5)) & 1;
          x  = ((x << 1) & 8'hFE) | fb;
        end
      end
      r[8*i +: 8] = 8'(x);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic eb, input int ec, input logic ed);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s_key%0d", tag, d), key_o[d], exp_key[d]);
      check($sformatf("%s_busy%0d", tag, d), 128'(busy_o[d]), 128'(eb));
      check($sformatf("%s_cnt%0d", tag, d), 128'(cnt_o[d]), 128'(ec));
      check($sformatf("%s_done%0d", tag, d), 128'(done_o[d]), 128'(ed));
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    load_i = 1'b1;
    key_i  = k;
    tick();
    load_i = 1'b0;
    for (int d = 0; d < NDUT; d++) exp_key[d] = k;
    check_all("load", 1'b0, 0, 1'b0);
    $display("[TB] load key=%h", k);
  endtask

  task automatic do_step(input logic dr);
    step_i = 1'b1;
    dir_i  = dr;
    tick();
    step_i = 1'b0;
    for (int d = 0; d < NDUT; d++) exp_key[d] = ref_cycle(exp_key[d], d, dr);
    check_all("step", 1'b0, 0, 1'b0);
    $display("[TB] step dir=%0d key0=%h", dr, key_o[0]);
  endtask

  task automatic do_run(input int n, input logic dr);
    start_i  = 1'b1;
    nsteps_i = CW'(n);
    dir_i    = dr;
    tick();
    start_i = 1'b0;
    if (n == 0) begin
      check_all("zero", 1'b0, 0, 1'b1);
      tick();
      check_all("zero_after", 1'b0, 0, 1'b0);
      $display("[TB] run n=0 key0=%h", key_o[0]);
      return;
    end
    for (int k = 0; k < n; k++) begin
      check_all("run", 1'b1, n - k, 1'b0);
      // noise on inputs that RUN must ignore
      dir_i    = 1'($urandom);
      step_i   = 1'($urandom);
      start_i  = 1'($urandom);
      nsteps_i = CW'($urandom);
      tick();
      for (int d = 0; d < NDUT; d++) exp_key[d] = ref_cycle(exp_key[d], d, dr);
    end
    step_i  = 1'b0;
    start_i = 1'b0;
    check_all("run_end", 1'b0, 0, 1'b1);
    tick();
    check_all("run_idle", 1'b0, 0, 1'b0);
    $display("[TB] run n=%0d dir=%0d key0=%h", n, dr, key_o[0]);
  endtask

  initial begin
    logic [127:0] k;
    logic [127:0] kb;
    int op;

    rst      = 1'b1;
    load_i   = 1'b0;
    key_i    = '0;
    start_i  = 1'b0;
    dir_i    = 1'b0;
    nsteps_i = '0;
    step_i   = 1'b0;
    for (int d = 0; d < NDUT; d++) exp_key[d] = '0;
    tick();
    tick();
    check_all("reset", 1'b0, 0, 1'b0);
    rst = 1'b0;
    tick();

    // single steps from all-0x01
    load_key({16{8'h01}});
    do_step(1'b0);
    check("step_fwd_40", key_o[0], {16{8'h40}});
    do_step(1'b1);
    check("step_inv_01", key_o[0], {16{8'h01}});

    // three-cycle forward run
    do_run(3, 1'b0);
    check("run3_54", key_o[0], {16{8'h54}});

    // round trips
    for (int r = 0; r < 2; r++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      do_run(56, 1'b0);
      do_run(56, 1'b1);
      for (int d = 0; d < NDUT; d++) check($sformatf("roundtrip%0d", d), key_o[d], k);
    end

    // zero-length run
    do_run(0, 1'b0);

    // abort on second active cycle of a 10-cycle run
    load_key({$urandom, $urandom, $urandom, $urandom});
    kb       = {$urandom, $urandom, $urandom, $urandom};
    start_i  = 1'b1;
    nsteps_i = CW'(10);
    dir_i    = 1'b0;
    tick();
    start_i = 1'b0;
    tick();
    for (int d = 0; d < NDUT; d++) exp_key[d] = ref_cycle(exp_key[d], d, 1'b0);
    check_all("abort_mid", 1'b1, 9, 1'b0);
    load_i = 1'b1;
    key_i  = kb;
    tick();
    load_i = 1'b0;
    for (int d = 0; d < NDUT; d++) exp_key[d] = kb;
    check_all("abort", 1'b0, 0, 1'b0);
    tick();
    check_all("abort_nodone", 1'b0, 0, 1'b0);
    $display("[TB] abort key0=%h", key_o[0]);

    // load beats start
    k        = {$urandom, $urandom, $urandom, $urandom};
    load_i   = 1'b1;
    key_i    = k;
    start_i  = 1'b1;
    nsteps_i = CW'(5);
    tick();
    load_i  = 1'b0;
    start_i = 1'b0;
    for (int d = 0; d < NDUT; d++) exp_key[d] = k;
    check_all("prio", 1'b0, 0, 1'b0);
    tick();
    check_all("prio_after", 1'b0, 0, 1'b0);
    $display("[TB] priority key0=%h", key_o[0]);

    // random mix
    for (int i = 0; i < 10; i++) begin
      op = int'($urandom_range(0, 2));
      case (op)
        0:       do_step(1'($urandom));
        1:       do_run(int'($urandom_range(1, 12)), 1'($urandom));
        default: load_key({$urandom, $urandom, $urandom, $urandom});
      endcase
    end

    // asynchronous reset in the middle of a run
    start_i  = 1'b1;
    nsteps_i = CW'(20);
    dir_i    = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("arst_key%0d", d), key_o[d], 128'(0));
      check($sformatf("arst_busy%0d", d), 128'(busy_o[d]), 128'(0));
      check($sformatf("arst_cnt%0d", d), 128'(cnt_o[d]), 128'(0));
      check($sformatf("arst_done%0d", d), 128'(done_o[d]), 128'(0));
      exp_key[d] = '0;
    end
    $display("[TB] async reset mid-run");
    tick();
    rst = 1'b0;
    tick();
    check_all("post_rst", 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
